// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice: controller state encoding,
// arbitration policy codes, default bus widths and the owner-index width helper.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_OWN     = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int DEF_DW = 8;
    localparam int DEF_AW = 16;

    // Owner index width: at least one bit even for a single master.
    function automatic int ow_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational rotating-priority picker.
//   req    : per-master request vector
//   base   : index of the last owner; round-robin search starts at base+1
//   mode   : MODE_FIXED = lowest index wins, MODE_RR = rotate from base+1
//   valid  : at least one request present
//   winner : index of the selected master
module bus_arb_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NDRV = 2,
    localparam int OW = ow_of(NDRV)
) (
    input  logic [NDRV-1:0] req,
    input  logic [OW-1:0]   base,
    input  logic            mode,
    output logic            valid,
    output logic [OW-1:0]   winner
);

    localparam int unsigned N = NDRV;

    int unsigned start;
    logic [OW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        start  = (mode == MODE_FIXED) ? 0 : ((32'(base) + 1) % N);
        // First hit in search order wins; later hits are masked by valid.
        for (int unsigned i = 0; i < N; i++) begin
            idx = OW'((start + i) % N);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Multi-master bus arbiter. Arbitrates NDRV internal masters onto one external
// bus, acquiring it through the BR/BA handshake, with fixed or round-robin
// policy, tenure limit, BA timeout and bus-loss recovery.
//   CLK/RST          : clock, asynchronous active-low reset
//   MODE             : 0 fixed priority, 1 round-robin (sampled at pick time)
//   RQ / OK          : per-master request / one-hot grant
//   M_ADDR..M_DT     : flattened per-master bus values
//   BR / BA          : external bus request / bus available
//   A_OUT..DT_OUT    : external bus drive values, muxed from OWNER
//   A_OE / D_OE      : pad enables; D_IN / RDATA : external data in / read data
//   OWNER / TIMEOUT  : current owner index / one-cycle BA-timeout pulse
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NDRV       = 2,
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int MAX_HOLD   = 16,
    parameter int BA_TIMEOUT = 255,
    localparam int OW = ow_of(NDRV)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               MODE,
    input  logic [NDRV-1:0]    RQ,
    output logic [NDRV-1:0]    OK,
    input  logic [NDRV*AW-1:0] M_ADDR,
    input  logic [NDRV*DW-1:0] M_WDATA,
    input  logic [NDRV-1:0]    M_RW,
    input  logic [NDRV-1:0]    M_IF,
    input  logic [NDRV-1:0]    M_DT,
    output logic               BR,
    input  logic               BA,
    output logic [AW-1:0]      A_OUT,
    output logic [DW-1:0]      D_OUT,
    output logic               RW_OUT,
    output logic               FI_OUT,
    output logic               DT_OUT,
    output logic               A_OE,
    output logic               D_OE,
    input  logic [DW-1:0]      D_IN,
    output logic [DW-1:0]      RDATA,
    output logic [OW-1:0]      OWNER,
    output logic               TIMEOUT
);

    localparam int WCW = $clog2(BA_TIMEOUT + 2);
    localparam int TCW = $clog2(MAX_HOLD + 2);

    arb_state_t      state_q, state_d;
    logic            br_q, br_d;
    logic [NDRV-1:0] ok_q, ok_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            a_oe_q, a_oe_d;
    logic            timeout_q, timeout_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [TCW-1:0]  tenure_q, tenure_d;
    logic [OW-1:0]   last_q, last_d;

    logic            pick_valid;
    logic [OW-1:0]   pick_winner;
    logic            grant;
    logic            preempt;

    bus_arb_pick #(.NDRV(NDRV)) u_pick (
        .req    (RQ),
        .base   (last_q),
        .mode   (MODE),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            br_q       <= 1'b0;
            ok_q       <= '0;
            owner_q    <= '0;
            a_oe_q     <= 1'b0;
            timeout_q  <= 1'b0;
            wait_cnt_q <= '0;
            tenure_q   <= '0;
            last_q     <= OW'(NDRV - 1);
        end else begin
            state_q    <= state_d;
            br_q       <= br_d;
            ok_q       <= ok_d;
            owner_q    <= owner_d;
            a_oe_q     <= a_oe_d;
            timeout_q  <= timeout_d;
            wait_cnt_q <= wait_cnt_d;
            tenure_q   <= tenure_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        br_d       = br_q;
        ok_d       = '0;
        owner_d    = owner_q;
        a_oe_d     = 1'b0;
        timeout_d  = 1'b0;
        wait_cnt_d = wait_cnt_q;
        tenure_d   = tenure_q;
        last_d     = last_q;
        grant      = 1'b0;
        preempt    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|RQ) begin
                    br_d       = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!(|RQ)) begin
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (BA && pick_valid) begin
                    grant = 1'b1;
                end else if (BA_TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_d == WCW'(BA_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        br_d      = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_OWN: begin
                ok_d   = ok_q;
                a_oe_d = 1'b1;
                if (tenure_q != TCW'(MAX_HOLD)) tenure_d = tenure_q + TCW'(1);
                // tenure_d counts the cycle now ending, so an owner gets
                // exactly MAX_HOLD cycles before yielding to a waiting master.
                preempt = (MAX_HOLD != 0) && (tenure_d >= TCW'(MAX_HOLD)) && (|(RQ & ~ok_q));
                if (!BA) begin
                    ok_d       = '0;
                    a_oe_d     = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end else if (!RQ[owner_q] || preempt) begin
                    ok_d    = '0;
                    a_oe_d  = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (pick_valid && BA) begin
                    grant = 1'b1;
                end else begin
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            state_d           = ST_OWN;
            ok_d              = '0;
            ok_d[pick_winner] = 1'b1;
            owner_d           = pick_winner;
            last_d            = pick_winner;
            tenure_d          = '0;
            a_oe_d            = 1'b1;
        end
    end

    // Bus values are held at zero unless an owner is driving, so the pad
    // enables can never expose stale master values.
    always_comb begin
        A_OUT  = '0;
        D_OUT  = '0;
        RW_OUT = 1'b0;
        FI_OUT = 1'b0;
        DT_OUT = 1'b0;
        if (a_oe_q) begin
            A_OUT  = M_ADDR[int'(owner_q)*AW +: AW];
            D_OUT  = M_WDATA[int'(owner_q)*DW +: DW];
            RW_OUT = M_RW[owner_q];
            FI_OUT = M_IF[owner_q];
            DT_OUT = M_DT[owner_q];
        end
    end

    assign D_OE    = ~RW_OUT & DT_OUT;
    assign RDATA   = D_IN;
    assign BR      = br_q;
    assign OK      = ok_q;
    assign OWNER   = owner_q;
    assign A_OE    = a_oe_q;
    assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed table and corner-case
// sequences, then randomized traffic against a behavioural model.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int NDRV     = 4;
    localparam int DW       = 8;
    localparam int AW       = 16;
    localparam int MAX_HOLD = 4;
    localparam int BA_TO    = 8;
    localparam int OW       = 2;

    logic               CLK, RST, MODE, BR, BA;
    logic               RW_OUT, FI_OUT, DT_OUT, A_OE, D_OE, TIMEOUT;
    logic [NDRV-1:0]    RQ, OK, M_RW, M_IF, M_DT;
    logic [NDRV*AW-1:0] M_ADDR;
    logic [NDRV*DW-1:0] M_WDATA;
    logic [AW-1:0]      A_OUT;
    logic [DW-1:0]      D_OUT, D_IN, RDATA;
    logic [OW-1:0]      OWNER;

    int n_vec = 0;
    int n_bad = 0;

    bus_arbiter #(
        .NDRV(NDRV), .DW(DW), .AW(AW), .MAX_HOLD(MAX_HOLD), .BA_TIMEOUT(BA_TO)
    ) dut (
        .CLK(CLK), .RST(RST), .MODE(MODE), .RQ(RQ), .OK(OK),
        .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RW(M_RW), .M_IF(M_IF), .M_DT(M_DT),
        .BR(BR), .BA(BA), .A_OUT(A_OUT), .D_OUT(D_OUT), .RW_OUT(RW_OUT),
        .FI_OUT(FI_OUT), .DT_OUT(DT_OUT), .A_OE(A_OE), .D_OE(D_OE),
        .D_IN(D_IN), .RDATA(RDATA), .OWNER(OWNER), .TIMEOUT(TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- behavioural model ----------------
    bit m_br, m_turn, m_to;
    int m_own;      // -1 when no master holds the bus
    int m_disp;     // last granted index (OWNER value)
    int m_last, m_wait, m_ten;

    function automatic void model_reset();
        m_br = 0; m_turn = 0; m_to = 0;
        m_own = -1; m_disp = 0; m_last = NDRV - 1;
        m_wait = 0; m_ten = 0;
    endfunction

    function automatic int m_pick();
        for (int i = 0; i < NDRV; i++) begin
            int idx;
            idx = (MODE == MODE_RR) ? (m_last + 1 + i) % NDRV : i;
            if (RQ[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void m_grant();
        int w;
        w = m_pick();
        m_own = w; m_disp = w; m_last = w; m_ten = 0;
    endfunction

    function automatic void model_step();
        bit any;
        any  = (RQ != 0);
        m_to = 0;
        if (!m_br) begin
            if (any) begin m_br = 1; m_wait = 0; end
        end else if (m_turn) begin
            m_turn = 0;
            if (any && BA) m_grant();
            else m_br = 0;
        end else if (m_own >= 0) begin
            if (m_ten < MAX_HOLD) m_ten++;
            if (!BA) begin
                m_own = -1; m_wait = 0;
            end else if (!RQ[m_own]) begin
                m_own = -1; m_turn = 1;
            end else if (MAX_HOLD != 0 && m_ten >= MAX_HOLD && (RQ & ~(4'(1) << m_own)) != 0) begin
                m_own = -1; m_turn = 1;
            end
        end else begin
            if (!any) m_br = 0;
            else if (BA) m_grant();
            else begin
                m_wait++;
                if (m_wait == BA_TO) begin m_to = 1; m_br = 0; end
            end
        end
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [63:0] pk(logic br, logic [3:0] ok, logic aoe, logic [1:0] own, logic to);
        return 64'({br, ok, aoe, own, to});
    endfunction

    function automatic logic [63:0] act_ctl();
        return pk(BR, OK, A_OE, OWNER, TIMEOUT);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0; RQ = '0; BA = 1'b0; MODE = MODE_FIXED;
        M_RW = '0; M_IF = '0; M_DT = '0; M_ADDR = '0; M_WDATA = '0; D_IN = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    typedef struct {
        logic [3:0] rq;
        logic       ba;
        logic       br;
        logic [3:0] ok;
        logic       aoe;
        logic [1:0] own;
    } vec_t;

    vec_t tbl[9];
    int   ba_hold;

    initial begin
        // fixed priority, masters 0/1, master 0 drops request at t5
        tbl[0] = '{4'h3, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[1] = '{4'h3, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[2] = '{4'h3, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[3] = '{4'h3, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[4] = '{4'h3, 1'b1, 1'b1, 4'h1, 1'b1, 2'd0};
        tbl[5] = '{4'h2, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0};
        tbl[6] = '{4'h2, 1'b1, 1'b1, 4'h2, 1'b1, 2'd1};
        tbl[7] = '{4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1};
        tbl[8] = '{4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1};

        RST = 1'b1;
        #2;
        do_reset();
        chk("reset_ctl", act_ctl(), pk(0, 0, 0, 0, 0));
        chk("reset_doe", 64'(D_OE), 64'(0));

        for (int i = 0; i < 9; i++) begin
            RQ = tbl[i].rq;
            BA = tbl[i].ba;
            cycle();
            chk($sformatf("tbl%0d", i), act_ctl(),
                pk(tbl[i].br, tbl[i].ok, tbl[i].aoe, tbl[i].own, 1'b0));
        end

        // round-robin, all requesting: tenures of 4 cycles plus 1 turnaround
        do_reset();
        MODE = MODE_RR; RQ = 4'hF; BA = 1'b1;
        cycle();
        chk("rr_br", act_ctl(), pk(1, 0, 0, 0, 0));
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                cycle();
                chk($sformatf("rr_own%0d_%0d", g, c), act_ctl(),
                    pk(1, 4'(1 << (g % 4)), 1, 2'(g % 4), 0));
            end
            if (g < 4) begin
                cycle();
                chk($sformatf("rr_rel%0d", g), act_ctl(), pk(1, 0, 0, 2'(g % 4), 0));
            end
        end

        // BA arrives 5 cycles after BR
        do_reset();
        RQ = 4'h1; BA = 1'b0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk($sformatf("late_wait%0d", k), act_ctl(), pk(1, 0, 0, 0, 0));
        end
        BA = 1'b1;
        cycle();
        chk("late_grant", act_ctl(), pk(1, 1, 1, 0, 0));

        // BA never arrives: timeout after 8 cycles in WAIT
        do_reset();
        RQ = 4'h1; BA = 1'b0;
        cycle();
        for (int k = 2; k <= 9; k++) begin
            cycle();
            if (k < 9) chk($sformatf("to_wait%0d", k), act_ctl(), pk(1, 0, 0, 0, 0));
            else       chk("to_pulse", act_ctl(), pk(0, 0, 0, 0, 1));
        end
        cycle();
        chk("to_rebr", act_ctl(), pk(1, 0, 0, 0, 0));

        // BA loss during ownership, then regrant of the same owner
        do_reset();
        RQ = 4'h5; BA = 1'b1;
        cycle(); cycle();
        chk("loss_own", act_ctl(), pk(1, 1, 1, 0, 0));
        cycle();
        BA = 1'b0;
        cycle();
        chk("loss_drop", act_ctl(), pk(1, 0, 0, 0, 0));
        BA = 1'b1;
        cycle();
        chk("loss_regrant", act_ctl(), pk(1, 1, 1, 0, 0));

        // bus mux: owner 2 write then read
        do_reset();
        M_ADDR  = {16'hDEAD, 16'h1234, 16'hBEEF, 16'h0F0F};
        M_WDATA = {8'h11, 8'hA5, 8'h22, 8'h33};
        M_RW = 4'b1011; M_DT = 4'b0100; M_IF = 4'b0000;
        RQ = 4'h4; BA = 1'b1;
        cycle(); cycle();
        chk("mux_ctl", act_ctl(), pk(1, 4'h4, 1, 2'd2, 0));
        chk("mux_write", 64'({A_OUT, D_OUT, RW_OUT, DT_OUT, D_OE}),
            64'({16'h1234, 8'hA5, 1'b0, 1'b1, 1'b1}));
        M_RW[2] = 1'b1; M_IF[2] = 1'b1; D_IN = 8'h3C;
        #1;
        chk("mux_read", 64'({RW_OUT, FI_OUT, D_OE, RDATA}), 64'({1'b1, 1'b1, 1'b0, 8'h3C}));

        // asynchronous reset during ownership
        M_RW[2] = 1'b0;
        #1;
        chk("rst_pre_doe", 64'(D_OE), 64'(1));
        RST = 1'b0;
        #1;
        chk("rst_async", 64'({BR, OK, A_OE, D_OE}), 64'(0));
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        cycle();
        chk("rst_br", act_ctl(), pk(1, 0, 0, 0, 0));
        cycle();
        chk("rst_grant", act_ctl(), pk(1, 4'h4, 1, 2'd2, 0));

        // randomized traffic against the model
        do_reset();
        ba_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NDRV; i++)
                if ($urandom_range(7) == 0) RQ[i] = ~RQ[i];
            if (ba_hold > 0) begin
                ba_hold--; BA = 1'b0;
            end else if ($urandom_range(39) == 0) begin
                ba_hold = $urandom_range(12, 1); BA = 1'b0;
            end else begin
                BA = 1'b1;
            end
            if ($urandom_range(49) == 0) MODE = ~MODE;
            M_ADDR  = {$urandom(), $urandom()};
            M_WDATA = $urandom();
            M_RW = 4'($urandom()); M_IF = 4'($urandom()); M_DT = 4'($urandom());
            D_IN = 8'($urandom());
            cycle();
            chk($sformatf("rnd_ctl%0d", n), act_ctl(),
                pk(m_br, (m_own >= 0) ? 4'(1 << m_own) : 4'h0, m_own >= 0, 2'(m_disp), m_to));
            if (m_own >= 0)
                chk($sformatf("rnd_bus%0d", n),
                    64'({A_OUT, D_OUT, RW_OUT, FI_OUT, DT_OUT, D_OE, RDATA}),
                    64'({M_ADDR[m_own*AW +: AW], M_WDATA[m_own*DW +: DW], M_RW[m_own],
                         M_IF[m_own], M_DT[m_own], ~M_RW[m_own] & M_DT[m_own], D_IN}));
            else
                chk($sformatf("rnd_idle%0d", n), 64'({D_OE, RDATA}), 64'({1'b0, D_IN}));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised multi-master bus arbiter: the successor of the fixed two-driver core/DMA bus unit. It arbitrates NDRV internal masters onto the single external bus and gains ownership through the external BR/BA handshake. Selectable fixed-priority or round-robin policy, a tenure limit, a bus-available timeout and bus-loss recovery. It sits between the core/DMA/other masters and the top-level tristate pads.

## Interface
- NDRV, 2: number of masters (2..8); index 0 = core
- DW, 8: data width
- AW, 16: address width
- MAX_HOLD, 16: max owner tenure in cycles while others request; 0 = unlimited
- BA_TIMEOUT, 255: max cycles waiting for BA; 0 = disabled
- OW = max(1, clog2(NDRV))

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- MODE  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- RQ  in  NDRV  per-master bus request, level
- OK  out  NDRV  per-master grant, one-hot or zero
- M_ADDR  in  NDRV*AW  flattened master addresses, master i at [i*AW +: AW]
- M_WDATA  in  NDRV*DW  flattened write data
- M_RW  in  NDRV  1 = read, 0 = write
- M_IF  in  NDRV  instruction fetch flag
- M_DT  in  NDRV  transfer strobe, cycle valid
- BR  out  1  external bus request
- BA  in  1  external bus available
- A_OUT  out  AW, D_OUT  out  DW, RW_OUT/FI_OUT/DT_OUT  out  1: external bus drive values
- A_OE  out  1  enable for address/RW/FI/DT pads
- D_OE  out  1  enable for data pads
- D_IN  in  DW  external data bus; RDATA  out  DW  read data returned to all masters
- OWNER  out  OW  index of current owner
- TIMEOUT  out  1  one-cycle pulse on BA timeout

## Operation
- States: IDLE, WAIT, OWN, RELEASE.
- IDLE: BR=0, OK=0, A_OE=0. Any RQ → BR<=1, go to WAIT.
- WAIT: BR=1; the wait counter counts up.
  - All RQ low → BR<=0, go to IDLE.
  - BA=1 → pick a winner from the current RQ, set OK[w]<=1 and OWNER<=w, clear the tenure counter, go to OWN.
  - Wait counter reaches BA_TIMEOUT → TIMEOUT<=1 for one cycle, BR<=0, go to IDLE.
- OWN: A_OE=1.
  - A_OUT/D_OUT/RW_OUT/FI_OUT/DT_OUT are a combinational mux from master OWNER.
  - D_OE = ~RW_OUT & DT_OUT.
  - The tenure counter saturates.
  - Exit priority, highest first:
    - BA=0 → OK<=0, go to WAIT, BR stays 1.
    - RQ[OWNER]=0 → go to RELEASE.
    - MAX_HOLD≠0, tenure ≥ MAX_HOLD and another RQ is high → go to RELEASE; a preempted owner re-competes with RQ still high.
- RELEASE: exactly one turnaround cycle with OK=0, A_OE=0, D_OE=0.
  - Next: if any RQ and BA=1, pick a winner and go to OWN; BR stays 1 throughout.
  - Else BR<=0, go to IDLE.
- Pick rules:
  - MODE=0: lowest set index wins.
  - MODE=1: search starts at last_owner+1 modulo NDRV; last_owner updates on each grant.
  - MODE is sampled only at pick time.
- RDATA = D_IN, combinational, valid when DT_OUT & RW_OUT.
- Reset values: BR=0, OK=0, OWNER=0, A_OE=0, TIMEOUT=0, state IDLE, counters 0, last_owner=NDRV-1 (so master 0 wins the first round-robin pick). D_OE=0 because A_OE=0 gates every bus output.

## Timing
- Registered outputs: BR, OK, OWNER, A_OE, TIMEOUT. Combinational outputs: bus values, D_OE, RDATA.
- RQ to OK: RQ sampled in IDLE → BR in cycle 1. With BA already high, OK rises in cycle 2.
- Owner handover: owner drops RQ → RELEASE next cycle → new OK one cycle later (2 cycles, no overlap).
- BA loss: BA sampled low → OK/A_OE low the next cycle. Masters must tolerate the loss of one in-flight transfer.
- RQ for a master that already holds OK may drop at any time; OK is cleared the following cycle.
- Reset asserted mid-OWN: all registered outputs clear immediately (asynchronous), which blanks A_OE/D_OE.

## Structure
- Shared package:
  - State encoding: ST_IDLE=0, ST_WAIT=1, ST_OWN=2, ST_RELEASE=3.
  - MODE_FIXED=0, MODE_RR=1.
  - Default DW/AW.
- Sub-module bus_arb_pick: combinational rotating-priority picker. Inputs: req[NDRV], base[OW], mode. Outputs: valid and winner index. Instantiated once.

## Test plan
- Fixed priority, NDRV=2, BA=1, RQ=2'b11 at t0 → BR=1 at t1, OK=2'b01 at t2. Drop RQ[0] at t5 → RELEASE at t6, OK=2'b10 at t7.
- Round-robin, NDRV=4, MAX_HOLD=4, all RQ high → owners 0,1,2,3,0. Each tenure: 4 cycles OWN + 1 RELEASE.
- BA arrives 5 cycles after BR → OK exactly 1 cycle after BA sampled high. With BA_TIMEOUT=8 and BA held low → TIMEOUT pulses once 8 cycles after entering WAIT; BR low for 1 cycle, then re-asserted.
- BA drops during OWN → next cycle OK=0, A_OE=0, BR=1. BA returns → same owner regranted under fixed priority.
- Owner 2 with M_ADDR=0x1234, M_WDATA=0xA5, RW=0, DT=1 → same cycle A_OUT=0x1234, D_OUT=0xA5, D_OE=1. Read with D_IN=0x3C → RDATA=0x3C.
- RST low during OWN → BR, OK, A_OE, D_OE all 0 before the next clock edge. After release with RQ high → normal 2-cycle grant.
